// File: rtl/core_halt_dump_monitor.sv
// End-of-run monitor: detects halt word or watchdog expiry, snapshots the register file, streams it out.
// Latency: DUMP entered the cycle after detection; one register per accepted beat, NREGS beats minimum.
// Backpressure: dump_valid/dump_idx/dump_data hold while dump_ready is low; nothing is dropped or skipped.
module core_halt_dump_monitor #(
    parameter int          XLEN       = 32,
    parameter int          NREGS      = 32,
    parameter logic [31:0] HALT_INSTR = 32'h0,
    parameter int          CNT_W      = 32,
    parameter longint      MAX_CYCLES = 1_000_000,
    localparam int         IDX_W      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    input  logic [NREGS*XLEN-1:0] regs,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [IDX_W-1:0]      dump_idx,
    output logic [XLEN-1:0]       dump_data,
    output logic                  halted,
    output logic                  timeout,
    output logic                  done,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instr_cnt
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Watchdog fires on the edge where the counter still shows MAX_CYCLES-1,
    // so exactly MAX_CYCLES RUN cycles elapse before DUMP.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREGS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [NREGS*XLEN-1:0]   snap;
    logic                    hit_halt;
    logic                    hit_wdog;
    logic                    stop_vld;
    logic                    beat_acc;
    logic                    last_beat;

    assign hit_halt  = instr_valid && (instr == HALT_INSTR);
    assign hit_wdog  = (MAX_CYCLES != 0) && (cycle_cnt == WDOG_LAST);
    assign stop_vld  = (state == S_RUN) && (hit_halt || hit_wdog);
    assign beat_acc  = (state == S_DUMP) && dump_ready;
    assign last_beat = (dump_idx == LAST_IDX);

    // Next-state: RUN until halt/watchdog, DUMP until the last beat is taken, DONE until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (hit_halt || hit_wdog) state_nxt = S_DUMP;
            S_DUMP:  if (beat_acc && last_beat) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    // State register; reset overrides any pending halt or beat.
    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    // Saturating run counters, frozen once the core has stopped; the halt word itself is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state == S_RUN) begin
            if (cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (instr_valid && !hit_halt && (instr_cnt != '1))
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    // Register-file snapshot and stop cause, captured on the detection edge; a halt beats the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap    <= '0;
            timeout <= 1'b0;
        end else if (stop_vld) begin
            snap    <= regs;
            timeout <= !hit_halt;
        end
    end

    // Beat index advances only on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst)
            dump_idx <= '0;
        else if (beat_acc)
            dump_idx <= last_beat ? '0 : dump_idx + 1'b1;
    end

    assign dump_valid = (state == S_DUMP);
    assign halted     = (state != S_RUN);
    assign done       = (state == S_DONE);
    // x0 is architecturally zero regardless of what the core drives on its slot.
    assign dump_data  = (dump_valid && (dump_idx != '0)) ? snap[dump_idx*XLEN +: XLEN] : '0;

endmodule

// File: tb/tb_core_halt_dump_monitor.sv
module tb_core_halt_dump_monitor;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 32;
    localparam int IDX_W = 5;
    localparam int MAXC  = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  instr_valid = 1'b0;
    logic [31:0]           instr = '0;
    logic [NREGS*XLEN-1:0] regs = '0;
    logic                  dump_ready = 1'b0;
    logic                  dump_valid;
    logic [IDX_W-1:0]      dump_idx;
    logic [XLEN-1:0]       dump_data;
    logic                  halted;
    logic                  timeout;
    logic                  done;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [CNT_W-1:0]      instr_cnt;

    core_halt_dump_monitor #(
        .XLEN(XLEN), .NREGS(NREGS), .HALT_INSTR(32'h0), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .regs(regs),
        .dump_ready(dump_ready), .dump_valid(dump_valid), .dump_idx(dump_idx),
        .dump_data(dump_data), .halted(halted), .timeout(timeout), .done(done),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          mcyc   = 0;
    int          minstr = 0;
    logic [31:0] rv[NREGS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input bit pattern);
        for (int i = 0; i < NREGS; i++) begin
            rv[i] = pattern ? (i * 32'h11111111) : $urandom;
            regs[i*XLEN +: XLEN] = rv[i];
        end
    endtask

    // Reference dump: every register of the halt-time file in index order, x0 reads as zero.
    task automatic push_snapshot();
        for (int i = 0; i < NREGS; i++) begin
            beat_t b;
            b.idx  = i;
            b.data = (i == 0) ? 32'h0 : rv[i];
            exp_q.push_back(b);
        end
    endtask

    // One RUN cycle of the reference model: every cycle counts, valid non-halt words count.
    task automatic run_cycle(input bit vld, input logic [31:0] word);
        instr_valid = vld;
        instr       = word;
        step();
        mcyc++;
        if (vld && word != 32'h0) minstr++;
        instr_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_dump_valid"}, dump_valid, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_instr_cnt"}, instr_cnt, 0);
        chk({tag, "_dump_idx"}, dump_idx, 0);
        chk({tag, "_dump_data"}, dump_data, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        dump_ready = 1'b0;
        exp_q.delete();
        repeat (3) step();
        rst = 1'b0;
        mcyc = 0;
        minstr = 0;
        check_cleared("reset");
    endtask

    task automatic check_stopped(input string tag, input bit exp_to);
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_timeout"}, timeout, exp_to);
        chk({tag, "_dump_valid"}, dump_valid, 1);
        chk({tag, "_dump_idx"}, dump_idx, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, mcyc);
        chk({tag, "_instr_cnt"}, instr_cnt, minstr);
    endtask

    // Drive dump_ready per mode (0 always, 1 pattern 1,0,0,1, 2 random) and scramble regs meanwhile.
    task automatic dump(input int mode, input int abort_at, output int acc, output int cyc);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        acc = 0;
        cyc = 0;
        while (acc < NREGS && cyc < 400) begin
            if (abort_at >= 0 && acc == abort_at) break;
            case (mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = pat[cyc % 4];
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode != 0) load_regs(1'b0);
            step();
            if (dump_ready) acc++;
            cyc++;
        end
        dump_ready = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_dump_valid"}, dump_valid, 0);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_cycle_frozen"}, cycle_cnt, mcyc);
        chk({tag, "_instr_frozen"}, instr_cnt, minstr);
    endtask

    // Monitor: pops the expected beat on each accepted handshake, checks hold while stalled.
    always @(negedge clk) begin
        if (!rst && dump_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got idx %0d data 0x%0h, expected no beat", dump_idx, dump_data);
            end else if (dump_ready) begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_idx", dump_idx, b.idx);
                chk("beat_data", dump_data, b.data);
            end else begin
                chk("stall_idx", dump_idx, exp_q[0].idx);
                chk("stall_data", dump_data, exp_q[0].data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int acc, cyc;

        // Halt after five instructions, then a full-rate dump of the i*0x11111111 pattern.
        do_reset();
        load_regs(1'b1);
        for (int k = 0; k < 5; k++) run_cycle(1'b1, $urandom | 32'h1);
        push_snapshot();
        run_cycle(1'b1, 32'h0);
        check_stopped("halt1", 1'b0);
        dump(0, -1, acc, cyc);
        chk("full_rate_beats", acc, NREGS);
        chk("full_rate_cycles", cyc, NREGS);
        check_done("done1");

        // DONE ignores instructions and ready.
        dump_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_valid = 1'b1;
            instr = (k == 0) ? 32'h0 : $urandom;
            step();
        end
        instr_valid = 1'b0;
        dump_ready = 1'b0;
        check_done("done_idle");

        // Random short runs, regs altered after halt, stalled and random ready.
        for (int it = 0; it < 4; it++) begin
            int n;
            do_reset();
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++) begin
                bit v = 1'($urandom_range(0, 1));
                run_cycle(v, v ? ($urandom | 32'h1) : $urandom_range(0, 1) * $urandom);
            end
            load_regs(1'b0);
            push_snapshot();
            run_cycle(1'b1, 32'h0);
            check_stopped("halt_rand", 1'b0);
            dump((it == 0) ? 1 : 2, -1, acc, cyc);
            chk("rand_beats", acc, NREGS);
            check_done("done_rand");
        end

        // Watchdog: no halt for MAXC cycles.
        do_reset();
        for (int k = 0; k < MAXC; k++) begin
            bit v = 1'($urandom_range(0, 1));
            load_regs(1'b0);
            if (k == MAXC - 1) push_snapshot();
            run_cycle(v, v ? ($urandom | 32'h1) : 32'h0);
            if (k < MAXC - 1) chk("wdog_not_yet", halted, 0);
        end
        check_stopped("wdog", 1'b1);
        chk("wdog_cycles", cycle_cnt, MAXC);

        // Reset mid-dump at idx 7 aborts straight back to RUN.
        dump(2, 7, acc, cyc);
        chk("abort_at_idx", dump_idx, 7);
        rst = 1'b1;
        exp_q.delete();
        step();
        check_cleared("abort");
        rst = 1'b0;
        mcyc = 0;
        minstr = 0;

        // Invalid zero words never halt; halt on the watchdog-expiry cycle wins.
        for (int k = 0; k < MAXC - 1; k++) begin
            run_cycle(1'b0, (k < 10) ? 32'h0 : $urandom);
            chk("invalid_zero_no_halt", halted, 0);
        end
        load_regs(1'b0);
        push_snapshot();
        run_cycle(1'b1, 32'h0);
        check_stopped("halt_vs_wdog", 1'b0);
        chk("halt_vs_wdog_cycles", cycle_cnt, MAXC);
        dump(2, -1, acc, cyc);
        chk("last_beats", acc, NREGS);
        check_done("done_last");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
